// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD VRAM test-pattern writer: pattern and FSM state encodings.
package lcd_pattern_gen_pkg;

  localparam int COLOR_W = 3;

  localparam logic [2:0] LCDPG_BANDS = 3'd0;
  localparam logic [2:0] LCDPG_BARS  = 3'd1;
  localparam logic [2:0] LCDPG_CHECK = 3'd2;
  localparam logic [2:0] LCDPG_XOR   = 3'd3;
  localparam logic [2:0] LCDPG_SOLID = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/lcdpg_pixel.sv
// Combinational pattern function: (mode, colour, x, y, frame count) -> VRAM pixel.
// With LCDPG_SCROLL_EN defined, x is offset by the frame count so patterns 1-3 scroll.
module lcdpg_pixel
  import lcd_pattern_gen_pkg::*;
#(
  parameter int X_W    = 7,
  parameter int Y_W    = 7,
  parameter int DATA_W = 4,
  parameter int FCNT_W = 8
) (
  input  logic [2:0]         mode,
  input  logic [COLOR_W-1:0] color,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [FCNT_W-1:0]  frame_cnt,
  output logic [DATA_W-1:0]  pixel
);

  logic [X_W-1:0] xs;
  logic           unused_frame_cnt;

  assign unused_frame_cnt = ^frame_cnt;

`ifdef LCDPG_SCROLL_EN
  assign xs = x + X_W'(frame_cnt);
`else
  assign xs = x;
`endif

  // Narrow frames (fewer than 3 or 4 bits) zero-fill the missing bit positions.
  logic [2:0] x_top, y_top, x_lo, y_lo;
  logic       x_b3, y_b3;

  if (X_W >= 3) begin : g_x3
    assign x_top = xs[X_W-1:X_W-3];
    assign x_lo  = xs[2:0];
  end else begin : g_xn
    assign x_top = 3'(xs) << (3 - X_W);
    assign x_lo  = 3'(xs);
  end

  if (Y_W >= 3) begin : g_y3
    assign y_top = y[Y_W-1:Y_W-3];
    assign y_lo  = y[2:0];
  end else begin : g_yn
    assign y_top = 3'(y) << (3 - Y_W);
    assign y_lo  = 3'(y);
  end

  if (X_W >= 4) begin : g_xb
    assign x_b3 = xs[3];
  end else begin : g_xbn
    assign x_b3 = 1'b0;
  end

  if (Y_W >= 4) begin : g_yb
    assign y_b3 = y[3];
  end else begin : g_ybn
    assign y_b3 = 1'b0;
  end

  logic [COLOR_W-1:0] c;

  always_comb begin
    c = '0;
    case (mode)
      LCDPG_BANDS: c = y_top;
      LCDPG_BARS:  c = x_top;
      LCDPG_CHECK: c = (x_b3 ^ y_b3) ? color : '0;
      LCDPG_XOR:   c = x_lo ^ y_lo;
      LCDPG_SOLID: c = color;
      default:     c = '0;
    endcase
  end

  assign pixel = DATA_W'(c);

endmodule

// File: rtl/lcd_pattern_gen.sv
// VRAM test-pattern writer: walks every pixel of the frame, one paced write per pixel.
// Optional macro LCDPG_SCROLL_EN makes patterns 1-3 scroll one pixel per frame.
module lcd_pattern_gen
  import lcd_pattern_gen_pkg::*;
#(
  parameter int X_W    = 7,
  parameter int Y_W    = 7,
  parameter int DATA_W = 4,
  parameter int PERIOD = 32768,
  parameter int FCNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 EN,
  input  logic [2:0]           MODE,
  input  logic [COLOR_W-1:0]   COLOR,
  output logic [X_W+Y_W-1:0]   VRAM_ADDR,
  output logic [DATA_W-1:0]    VRAM_DATA,
  output logic                 VRAM_WE,
  input  logic                 VRAM_RDY,
  output logic                 FRAME_DONE,
  output logic [FCNT_W-1:0]    FRAME_CNT,
  output logic [1:0]           DBG_STATE
);

  localparam int A_W   = X_W + Y_W;
  localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((PERIOD > 1) ? PERIOD - 2 : 0);
  localparam bit   FAST = (PERIOD == 1);

  // Handshake: VRAM_WE is valid; a write transfers on each rising CLK edge where
  // VRAM_WE and VRAM_RDY are both high. ADDR/DATA are held stable until that edge.
  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [A_W-1:0]     addr;
  logic [2:0]         mode_q;
  logic [COLOR_W-1:0] color_q;
  logic               we;
  logic               done;
  logic [FCNT_W-1:0]  fcnt;
  logic               last_pix;

  assign last_pix = &addr;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= ST_IDLE;
      div     <= '0;
      addr    <= '0;
      mode_q  <= '0;
      color_q <= '0;
      we      <= 1'b0;
      done    <= 1'b0;
      fcnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          we <= 1'b0;
          if (EN) begin
            mode_q  <= MODE;
            color_q <= COLOR;
            addr    <= '0;
            div     <= '0;
            state   <= FAST ? ST_ISSUE : ST_WAIT;
            we      <= FAST;
          end
        end
        ST_WAIT: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            state <= ST_ISSUE;
            we    <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (VRAM_RDY) begin
            div <= '0;
            if (last_pix) begin
              done <= 1'b1;
              fcnt <= fcnt + 1'b1;
              addr <= '0;
              // EN only matters at frame boundaries; a dropped EN lets the frame finish.
              if (EN) begin
                mode_q  <= MODE;
                color_q <= COLOR;
                state   <= FAST ? ST_ISSUE : ST_WAIT;
                we      <= FAST;
              end else begin
                state <= ST_IDLE;
                we    <= 1'b0;
              end
            end else begin
              addr  <= addr + 1'b1;
              state <= FAST ? ST_ISSUE : ST_WAIT;
              we    <= FAST;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          we    <= 1'b0;
        end
      endcase
    end
  end

  lcdpg_pixel #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .DATA_W (DATA_W),
    .FCNT_W (FCNT_W)
  ) u_pixel (
    .mode      (mode_q),
    .color     (color_q),
    .x         (addr[X_W-1:0]),
    .y         (addr[A_W-1:X_W]),
    .frame_cnt (fcnt),
    .pixel     (VRAM_DATA)
  );

  assign VRAM_ADDR  = addr;
  assign VRAM_WE    = we;
  assign FRAME_DONE = done;
  assign FRAME_CNT  = fcnt;
  assign DBG_STATE  = state;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: three instances (2x2 PERIOD 4, 3x3 PERIOD 1, 4x4 PERIOD 2).
module tb_lcd_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  // instance a: 2x2, PERIOD 4
  logic rst_a, en_a, rdy_a, we_a, done_a;
  logic [2:0] mode_a, color_a;
  logic [3:0] addr_a, data_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;
  // instance b: 3x3, PERIOD 1
  logic rst_b, en_b, rdy_b, we_b, done_b;
  logic [2:0] mode_b, color_b;
  logic [5:0] addr_b;
  logic [3:0] data_b;
  logic [7:0] cnt_b;
  logic [1:0] st_b;
  // instance c: 4x4, PERIOD 2
  logic rst_c, en_c, rdy_c, we_c, done_c;
  logic [2:0] mode_c, color_c;
  logic [7:0] addr_c;
  logic [3:0] data_c;
  logic [7:0] cnt_c;
  logic [1:0] st_c;

  lcd_pattern_gen #(.X_W(2), .Y_W(2), .DATA_W(4), .PERIOD(4), .FCNT_W(8)) dut_a (
    .CLK(clk), .RST_X(rst_a), .EN(en_a), .MODE(mode_a), .COLOR(color_a),
    .VRAM_ADDR(addr_a), .VRAM_DATA(data_a), .VRAM_WE(we_a), .VRAM_RDY(rdy_a),
    .FRAME_DONE(done_a), .FRAME_CNT(cnt_a), .DBG_STATE(st_a));

  lcd_pattern_gen #(.X_W(3), .Y_W(3), .DATA_W(4), .PERIOD(1), .FCNT_W(8)) dut_b (
    .CLK(clk), .RST_X(rst_b), .EN(en_b), .MODE(mode_b), .COLOR(color_b),
    .VRAM_ADDR(addr_b), .VRAM_DATA(data_b), .VRAM_WE(we_b), .VRAM_RDY(rdy_b),
    .FRAME_DONE(done_b), .FRAME_CNT(cnt_b), .DBG_STATE(st_b));

  lcd_pattern_gen #(.X_W(4), .Y_W(4), .DATA_W(4), .PERIOD(2), .FCNT_W(8)) dut_c (
    .CLK(clk), .RST_X(rst_c), .EN(en_c), .MODE(mode_c), .COLOR(color_c),
    .VRAM_ADDR(addr_c), .VRAM_DATA(data_c), .VRAM_WE(we_c), .VRAM_RDY(rdy_c),
    .FRAME_DONE(done_c), .FRAME_CNT(cnt_c), .DBG_STATE(st_c));

  // Reference pattern; narrow-axis BANDS/BARS are not exercised.
  function automatic logic [2:0] model_pix(int xw, int yw, int mode, int color, int addr, int fcnt);
    int x, y, xs;
    x = addr & ((1 << xw) - 1);
    y = addr >> xw;
`ifdef LCDPG_SCROLL_EN
    xs = (x + fcnt) & ((1 << xw) - 1);
`else
    xs = x + 0 * fcnt;
`endif
    case (mode)
      0: return 3'((y >> (yw - 3)) & 7);
      1: return 3'((xs >> (xw - 3)) & 7);
      2: return (((xs >> 3) ^ (y >> 3)) & 1) != 0 ? 3'(color) : 3'd0;
      3: return 3'((xs ^ y) & 7);
      4: return 3'(color);
      default: return 3'd0;
    endcase
  endfunction

  task automatic push_frame(input int xw, input int yw, input int mode, input int color, input int fcnt);
    for (int i = 0; i < (1 << (xw + yw)); i++)
      exp_q.push_back({8'(model_pix(xw, yw, mode, color, i, fcnt)), 24'(i)});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({we_a, addr_a, data_a, done_a, cnt_a, st_a} !== '0) begin
      fails++; $display("FAIL reset_a got %h exp 0", {we_a, addr_a, data_a, done_a, cnt_a, st_a});
    end
    tests++;
    if ({we_b, addr_b, data_b, done_b, cnt_b, st_b} !== '0) begin
      fails++; $display("FAIL reset_b got %h exp 0", {we_b, addr_b, data_b, done_b, cnt_b, st_b});
    end
    tests++;
    if ({we_c, addr_c, data_c, done_c, cnt_c, st_c} !== '0) begin
      fails++; $display("FAIL reset_c got %h exp 0", {we_c, addr_c, data_c, done_c, cnt_c, st_c});
    end
  endtask

  task automatic test_solid();
    int n, last_cyc;
    logic [31:0] e;
    exp_q.delete();
    mode_a = 3'd4; color_a = 3'd5; en_a = 1'b1; rdy_a = 1'b1;
    push_frame(2, 2, 4, 5, 0);
    @(negedge clk); rst_a = 1'b1;
    n = 0; last_cyc = 0;
    for (int c = 0; c < 300 && n < 16; c++) begin
      @(negedge clk);
      if (we_a && rdy_a) begin
        e = exp_q.pop_front();
        tests++;
        if ({8'(data_a), 24'(addr_a)} !== e) begin
          fails++; $display("FAIL solid_pix n=%0d got %h exp %h", n, {8'(data_a), 24'(addr_a)}, e);
        end
        if (n > 0) begin
          tests++;
          if (cyc - last_cyc != 4) begin
            fails++; $display("FAIL solid_spacing n=%0d got %0d exp 4", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc; n++;
        en_a = 1'b0;
      end
    end
    tests++;
    if (n != 16) begin fails++; $display("FAIL solid_timeout got %0d accepts exp 16", n); end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b1 || cnt_a !== 8'd1) begin
      fails++; $display("FAIL solid_done got done=%b cnt=%0d exp done=1 cnt=1", done_a, cnt_a);
    end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0) begin fails++; $display("FAIL solid_done_pulse got %b exp 0", done_a); end
    repeat (8) @(negedge clk);
    tests++;
    if (we_a !== 1'b0 || st_a !== 2'd0) begin
      fails++; $display("FAIL solid_idle got we=%b st=%0d exp we=0 st=0", we_a, st_a);
    end
  endtask

  task automatic test_period1();
    int n, last_cyc;
    bit started;
    logic [31:0] e;
    exp_q.delete();
    mode_b = 3'd0; color_b = 3'd0; en_b = 1'b1; rdy_b = 1'b1;
    push_frame(3, 3, 0, 0, 0);
    @(negedge clk); rst_b = 1'b1;
    n = 0; last_cyc = 0; started = 1'b0;
    for (int c = 0; c < 300 && n < 64; c++) begin
      @(negedge clk);
      if (started) begin
        tests++;
        if (we_b !== 1'b1) begin fails++; $display("FAIL p1_we_gap n=%0d got %b exp 1", n, we_b); end
      end
      if (we_b && rdy_b) begin
        e = exp_q.pop_front();
        tests++;
        if ({8'(data_b), 24'(addr_b)} !== e) begin
          fails++; $display("FAIL p1_pix n=%0d got %h exp %h", n, {8'(data_b), 24'(addr_b)}, e);
        end
        if (n > 0) begin
          tests++;
          if (cyc - last_cyc != 1) begin
            fails++; $display("FAIL p1_spacing n=%0d got %0d exp 1", n, cyc - last_cyc);
          end
        end
        if (addr_b == 6'd8) begin
          tests++;
          if (data_b !== 4'd1) begin fails++; $display("FAIL p1_addr8 got %0d exp 1", data_b); end
        end
        if (addr_b == 6'd63) begin
          tests++;
          if (data_b !== 4'd7) begin fails++; $display("FAIL p1_addr63 got %0d exp 7", data_b); end
        end
        last_cyc = cyc; started = 1'b1; n++;
        en_b = 1'b0;
      end
    end
    tests++;
    if (n != 64) begin fails++; $display("FAIL p1_timeout got %0d accepts exp 64", n); end
    @(negedge clk);
    tests++;
    if (done_b !== 1'b1 || cnt_b !== 8'd1 || we_b !== 1'b0 || st_b !== 2'd0) begin
      fails++; $display("FAIL p1_end got done=%b cnt=%0d we=%b st=%0d exp 1 1 0 0", done_b, cnt_b, we_b, st_b);
    end
  endtask

  task automatic test_stall();
    int n, last_cyc;
    bit stalled;
    logic [31:0] e;
    logic [2:0] exp5;
    exp_q.delete();
    rst_a = 1'b0;
    @(negedge clk);
    tests++;
    if (cnt_a !== 8'd0) begin fails++; $display("FAIL stall_reset_cnt got %0d exp 0", cnt_a); end
    mode_a = 3'd3; color_a = 3'd0; en_a = 1'b1; rdy_a = 1'b1;
    push_frame(2, 2, 3, 0, 0);
    exp5 = model_pix(2, 2, 3, 0, 5, 0);
    @(negedge clk); rst_a = 1'b1;
    n = 0; last_cyc = 0; stalled = 1'b0;
    for (int c = 0; c < 400 && n < 16; c++) begin
      @(negedge clk);
      if (we_a && addr_a == 4'd5 && !stalled) begin
        stalled = 1'b1; rdy_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          tests++;
          if (we_a !== 1'b1 || addr_a !== 4'd5 || data_a !== 4'(exp5)) begin
            fails++;
            $display("FAIL stall_hold k=%0d got we=%b addr=%0d data=%0d exp 1 5 %0d", k, we_a, addr_a, data_a, exp5);
          end
        end
        rdy_a = 1'b1;
      end
      if (we_a && rdy_a) begin
        e = exp_q.pop_front();
        tests++;
        if ({8'(data_a), 24'(addr_a)} !== e) begin
          fails++; $display("FAIL stall_pix n=%0d got %h exp %h", n, {8'(data_a), 24'(addr_a)}, e);
        end
        if (n > 0 && addr_a != 4'd5) begin
          tests++;
          if (cyc - last_cyc != 4) begin
            fails++; $display("FAIL stall_spacing n=%0d got %0d exp 4", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc; n++;
        en_a = 1'b0;
      end
    end
    tests++;
    if (n != 16 || !stalled) begin fails++; $display("FAIL stall_timeout got %0d accepts exp 16", n); end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b1 || cnt_a !== 8'd1) begin
      fails++; $display("FAIL stall_done got done=%b cnt=%0d exp 1 1", done_a, cnt_a);
    end
  endtask

  task automatic test_mode_change();
    int n;
    logic [31:0] e;
    exp_q.delete();
    mode_c = 3'd2; color_c = 3'd3; en_c = 1'b1; rdy_c = 1'b1;
    push_frame(4, 4, 2, 3, 0);
    @(negedge clk); rst_c = 1'b1;
    n = 0;
    for (int c = 0; c < 1000 && n < 256; c++) begin
      @(negedge clk);
      if (we_c && rdy_c) begin
        e = exp_q.pop_front();
        tests++;
        if ({8'(data_c), 24'(addr_c)} !== e) begin
          fails++; $display("FAIL mode_pix n=%0d got %h exp %h", n, {8'(data_c), 24'(addr_c)}, e);
        end
        n++;
        if (n == 20) begin mode_c = 3'd1; color_c = 3'd7; en_c = 1'b0; end
      end
    end
    tests++;
    if (n != 256) begin fails++; $display("FAIL mode_timeout got %0d accepts exp 256", n); end
    @(negedge clk);
    tests++;
    if (done_c !== 1'b1 || cnt_c !== 8'd1) begin
      fails++; $display("FAIL mode_done got done=%b cnt=%0d exp 1 1", done_c, cnt_c);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (we_c !== 1'b0 || st_c !== 2'd0) begin
      fails++; $display("FAIL mode_idle got we=%b st=%0d exp 0 0", we_c, st_c);
    end
  endtask

  task automatic test_wrap();
    int k;
    rst_b = 1'b0;
    mode_b = 3'd4; color_b = 3'd2; en_b = 1'b1; rdy_b = 1'b1;
    @(negedge clk); rst_b = 1'b1;
    k = 0;
    for (int c = 0; c < 17000 && k < 256; c++) begin
      @(negedge clk);
      if (done_b) begin
        k++;
        tests++;
        if (cnt_b !== 8'(k)) begin fails++; $display("FAIL wrap_cnt k=%0d got %0d exp %0d", k, cnt_b, 8'(k)); end
        if (k == 255) en_b = 1'b0;
      end
    end
    tests++;
    if (k != 256) begin fails++; $display("FAIL wrap_timeout got %0d frames exp 256", k); end
    repeat (3) @(negedge clk);
    tests++;
    if (we_b !== 1'b0 || cnt_b !== 8'd0) begin
      fails++; $display("FAIL wrap_end got we=%b cnt=%0d exp 0 0", we_b, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    rst_a = 1'b0;
    mode_a = 3'd4; color_a = 3'd5; en_a = 1'b1; rdy_a = 1'b1;
    @(negedge clk); rst_a = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (we_a && addr_a == 4'd9) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rmid_timeout got no WE at addr 9 exp WE at addr 9"); end
    #1 rst_a = 1'b0;
    #1;
    tests++;
    if ({we_a, addr_a, data_a, done_a, cnt_a, st_a} !== '0) begin
      fails++; $display("FAIL rmid_abort got %h exp 0", {we_a, addr_a, data_a, done_a, cnt_a, st_a});
    end
    @(negedge clk); rst_a = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      tests++;
      if (done_a !== 1'b0) begin fails++; $display("FAIL rmid_done got %b exp 0", done_a); end
      if (we_a) found = 1'b1;
    end
    tests++;
    if (!found || addr_a !== 4'd0 || cnt_a !== 8'd0 || data_a !== 4'd5) begin
      fails++; $display("FAIL rmid_restart got addr=%0d cnt=%0d data=%0d exp 0 0 5", addr_a, cnt_a, data_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_scroll();
    int n;
    logic [31:0] e;
    exp_q.delete();
    rst_b = 1'b0;
    mode_b = 3'd3; color_b = 3'd0; en_b = 1'b1; rdy_b = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(3, 3, 3, 0, f);
    @(negedge clk); rst_b = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 192; c++) begin
      @(negedge clk);
      if (we_b && rdy_b) begin
        e = exp_q.pop_front();
        tests++;
        if ({8'(data_b), 24'(addr_b)} !== e) begin
          fails++; $display("FAIL scroll_pix n=%0d got %h exp %h", n, {8'(data_b), 24'(addr_b)}, e);
        end
        if (n >= 128 && addr_b == 6'd1) begin
          tests++;
`ifdef LCDPG_SCROLL_EN
          if (data_b !== 4'd3) begin fails++; $display("FAIL scroll_x1 got %0d exp 3", data_b); end
`else
          if (data_b !== 4'd1) begin fails++; $display("FAIL scroll_x1 got %0d exp 1", data_b); end
`endif
        end
        n++;
        if (n == 130) en_b = 1'b0;
      end
    end
    tests++;
    if (n != 192) begin fails++; $display("FAIL scroll_timeout got %0d accepts exp 192", n); end
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0; rdy_a = 1'b1; mode_a = '0; color_a = '0;
    rst_b = 1'b0; en_b = 1'b0; rdy_b = 1'b1; mode_b = '0; color_b = '0;
    rst_c = 1'b0; en_c = 1'b0; rdy_c = 1'b1; mode_c = '0; color_c = '0;
    test_reset();
    test_solid();
    test_period1();
    test_stall();
    test_mode_change();
    test_wrap();
    test_reset_mid();
    test_scroll();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
